filter_acc_unit_gen: RTL and testbench

- Producer of the per-unit flag/result pair consumed by the accumulation delay/hold controller.
- Accumulates a sample stream over programmable-length units and compares each unit sum against hysteretic thresholds.
- Emits one `filter_unit_flag_o` pulse per completed unit, with `filter_acc_result_o` valid and stable in that cycle.
- Sits between the sample front-end (ADC/filter pipeline) and the acc delay/hold stage, in the same clock domain.

---
 rtl/filter_acc_unit_gen.sv | 163 ++++++++++++++++
 tb/tb_filter_acc_unit_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/filter_acc_unit_gen.sv
// filter_acc_unit_gen: accumulates an unsigned sample stream over units of a
// programmable length and applies a hysteretic threshold compare to each unit
// sum. Emits a one-cycle flag per completed unit.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   acc_enable_i          block enable; low forces idle and clears all state
//   sample_vld_i          sample qualifier, one sample per high cycle
//   sample_data_i         unsigned sample
//   unit_len_i            samples per unit (0 behaves as 1)
//   thresh_hi_i           set threshold (final >= hi sets the result)
//   thresh_lo_i           clear threshold (final < lo clears the result)
//   filter_unit_flag_o    one-cycle pulse per completed unit
//   filter_acc_result_o   hysteretic result, changes only with the flag
//   unit_sum_o            sum of the last completed unit
module filter_acc_unit_gen #(
    parameter real         TCQ    = 0.1,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SUM_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              acc_enable_i,
    input  logic              sample_vld_i,
    input  logic [DATA_W-1:0] sample_data_i,
    input  logic [15:0]       unit_len_i,
    input  logic [SUM_W-1:0]  thresh_hi_i,
    input  logic [SUM_W-1:0]  thresh_lo_i,
    output logic              filter_unit_flag_o,
    output logic              filter_acc_result_o,
    output logic [SUM_W-1:0]  unit_sum_o
);

    localparam int unsigned LEN_W = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Elaboration-time guard: the accumulator must hold a full unit without wrap.
    if (SUM_W < DATA_W + LEN_W || TCQ < 0.0) begin : g_bad_params
        $error("filter_acc_unit_gen: SUM_W too small or negative TCQ");
    end

    logic [0:0]       state_q,  state_d;
    logic [SUM_W-1:0] acc_q,    acc_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic [LEN_W-1:0] len_q,    len_d;
    logic [SUM_W-1:0] hi_q,     hi_d;
    logic [SUM_W-1:0] lo_q,     lo_d;
    logic             flag_q,   flag_d;
    logic             result_q, result_d;
    logic [SUM_W-1:0] sum_q,    sum_d;

    logic             first_c;
    logic [LEN_W-1:0] cur_len_c;
    logic [LEN_W-1:0] last_idx_c;
    logic [SUM_W-1:0] cur_hi_c;
    logic [SUM_W-1:0] cur_lo_c;
    logic [SUM_W-1:0] sum_next_c;
    logic             last_c;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        flag_d   = 1'b0;
        result_d = result_q;
        sum_d    = sum_q;

        // At the first sample of a unit the live settings are the ones being
        // latched, so they already govern this sample (matters for length 1).
        first_c    = (cnt_q == '0);
        cur_len_c  = first_c ? unit_len_i  : len_q;
        cur_hi_c   = first_c ? thresh_hi_i : hi_q;
        cur_lo_c   = first_c ? thresh_lo_i : lo_q;
        last_idx_c = (cur_len_c == '0) ? '0 : cur_len_c - LEN_W'(1);
        sum_next_c = acc_q + SUM_W'(sample_data_i);
        last_c     = sample_vld_i && (cnt_q == last_idx_c);

        case (state_q)
            ST_IDLE: begin
                acc_d    = '0;
                cnt_d    = '0;
                result_d = 1'b0;
                sum_d    = '0;
                if (acc_enable_i) begin
                    state_d = ST_RUN;
                    len_d   = unit_len_i;
                    hi_d    = thresh_hi_i;
                    lo_d    = thresh_lo_i;
                end
            end
            ST_RUN: begin
                if (!acc_enable_i) begin
                    // Partial unit is dropped without a flag.
                    state_d  = ST_IDLE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    result_d = 1'b0;
                    sum_d    = '0;
                end else if (sample_vld_i) begin
                    if (first_c) begin
                        len_d = unit_len_i;
                        hi_d  = thresh_hi_i;
                        lo_d  = thresh_lo_i;
                    end
                    if (last_c) begin
                        acc_d  = '0;
                        cnt_d  = '0;
                        flag_d = 1'b1;
                        sum_d  = sum_next_c;
                        // Set rule wins over clear if thresholds are inverted.
                        if (sum_next_c >= cur_hi_c) begin
                            result_d = 1'b1;
                        end else if (sum_next_c < cur_lo_c) begin
                            result_d = 1'b0;
                        end
                    end else begin
                        acc_d = sum_next_c;
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            flag_q   <= 1'b0;
            result_q <= 1'b0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            sum_q    <= sum_d;
        end
    end

    assign filter_unit_flag_o  = flag_q;
    assign filter_acc_result_o = result_q;
    assign unit_sum_o          = sum_q;

endmodule

// File: tb/tb_filter_acc_unit_gen.sv
// Directed, table-driven bench for filter_acc_unit_gen. Each table row is one
// clock cycle: inputs applied before the edge, outputs compared 1 ns after it.
module tb_filter_acc_unit_gen;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SUM_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [15:0]       len;
    logic [SUM_W-1:0]  hi;
    logic [SUM_W-1:0]  lo;
    logic              flag;
    logic              res;
    logic [SUM_W-1:0]  sum;

    always #5 clk = ~clk;

    filter_acc_unit_gen #(
        .TCQ    (0.1),
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .acc_enable_i        (en),
        .sample_vld_i        (vld),
        .sample_data_i       (data),
        .unit_len_i          (len),
        .thresh_hi_i         (hi),
        .thresh_lo_i         (lo),
        .filter_unit_flag_o  (flag),
        .filter_acc_result_o (res),
        .unit_sum_o          (sum)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        vld;
        logic [15:0] data;
        logic [15:0] len;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        e_flag;
        logic        e_res;
        logic [31:0] e_sum;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic e, input logic v,
                                input logic [15:0] d, input logic [15:0] l,
                                input logic [31:0] h, input logic [31:0] lw,
                                input logic ef, input logic er, input logic [31:0] es);
        vec_t t;
        t.rst = r; t.en = e; t.vld = v; t.data = d; t.len = l; t.hi = h; t.lo = lw;
        t.e_flag = ef; t.e_res = er; t.e_sum = es;
        vecs.push_back(t);
    endfunction

    initial begin
        int early_flags;

        // Basic unit: len 4, 10+20+30+40 = 100 >= hi.
        add(0,1,0, 0,4,100,50, 0,0,0);
        add(0,1,1,10,4,100,50, 0,0,0);
        add(0,1,1,20,4,100,50, 0,0,0);
        add(0,1,1,30,4,100,50, 0,0,0);
        add(0,1,1,40,4,100,50, 1,1,100);
        add(0,1,0, 0,4,100,50, 0,1,100);
        // Hysteresis, len 2: sums 120,80,40,80,100 -> 1,1,0,0,1.
        add(0,1,1,60,2,100,50, 0,1,100);
        add(0,1,1,60,2,100,50, 1,1,120);
        add(0,1,1,40,2,100,50, 0,1,120);
        add(0,1,1,40,2,100,50, 1,1,80);
        add(0,1,1,20,2,100,50, 0,1,80);
        add(0,1,1,20,2,100,50, 1,0,40);
        add(0,1,1,40,2,100,50, 0,0,40);
        add(0,1,1,40,2,100,50, 1,0,80);
        add(0,1,1,50,2,100,50, 0,0,80);
        add(0,1,1,50,2,100,50, 1,1,100);
        // Gapped valid, len 3 reprogrammed to 5 after the first sample.
        add(0,1,1, 5,3,100,50, 0,1,100);
        add(0,1,0, 0,5,100,50, 0,1,100);
        add(0,1,0, 0,5,100,50, 0,1,100);
        add(0,1,1, 5,5,100,50, 0,1,100);
        add(0,1,0, 0,5,100,50, 0,1,100);
        add(0,1,1, 5,5,100,50, 1,0,15);
        add(0,1,1,30,5,100,50, 0,0,15);
        add(0,1,1,30,5,100,50, 0,0,15);
        add(0,1,1,30,5,100,50, 0,0,15);
        add(0,1,1,30,5,100,50, 0,0,15);
        add(0,1,1,30,5,100,50, 1,1,150);
        // len 0 acts as 1: back-to-back flags; hi=lo=8 probes the >= edge.
        add(0,1,1, 7,0,8,8, 1,0,7);
        add(0,1,1, 8,0,8,8, 1,1,8);
        add(0,1,1, 9,0,8,8, 1,1,9);
        add(0,1,0, 0,0,8,8, 0,1,9);
        // Disable mid-unit: partial discarded, result cleared, fresh unit of 4.
        add(0,1,1, 1,4,3,2, 0,1,9);
        add(0,1,1, 1,4,3,2, 0,1,9);
        add(0,0,1, 1,4,3,2, 0,0,0);
        add(0,1,0, 0,4,3,2, 0,0,0);
        add(0,1,1, 1,4,3,2, 0,0,0);
        add(0,1,1, 1,4,3,2, 0,0,0);
        add(0,1,1, 1,4,3,2, 0,0,0);
        add(0,1,1, 1,4,3,2, 1,1,4);
        // Inverted thresholds (hi=10 < lo=20): set rule has priority.
        add(0,1,1,15,1,10,20, 1,1,15);
        add(0,1,1, 5,1,10,20, 1,0,5);
        add(0,1,1,15,1,10,20, 1,1,15);
        // Reset mid-unit: no flag, then a clean unit of 4x2.
        add(0,1,1, 2,4,3,2, 0,1,15);
        add(0,1,1, 2,4,3,2, 0,1,15);
        add(1,1,1, 2,4,3,2, 0,0,0);
        add(0,1,0, 0,4,3,2, 0,0,0);
        add(0,1,1, 2,4,3,2, 0,0,0);
        add(0,1,1, 2,4,3,2, 0,0,0);
        add(0,1,1, 2,4,3,2, 0,0,0);
        add(0,1,1, 2,4,3,2, 1,1,8);

        rst = 1'b1; en = 1'b0; vld = 1'b0; data = '0; len = '0; hi = '0; lo = '0;
        tick();
        tick();
        check("reset_flag", 0, 32'(flag), 32'd0);
        check("reset_res",  0, 32'(res),  32'd0);
        check("reset_sum",  0, sum,       32'd0);
        rst = 1'b0;
        tick();
        check("idle_flag", 0, 32'(flag), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; vld = vecs[i].vld; data = vecs[i].data;
            len = vecs[i].len; hi = vecs[i].hi; lo = vecs[i].lo;
            tick();
            check("flag", i, 32'(flag), 32'(vecs[i].e_flag));
            check("result", i, 32'(res), 32'(vecs[i].e_res));
            check("unit_sum", i, sum, vecs[i].e_sum);
        end

        // Max-value unit: 65535 samples of 0xFFFF, exactly reaching hi.
        rst = 1'b1; en = 1'b0; vld = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; len = 16'hFFFF; hi = 32'hFFFE_0001; lo = 32'd0;
        tick();
        vld = 1'b1; data = 16'hFFFF;
        early_flags = 0;
        for (int i = 0; i < 65534; i++) begin
            tick();
            if (flag) early_flags++;
        end
        check("max_early_flags", 0, 32'(early_flags), 32'd0);
        tick();
        vld = 1'b0;
        check("max_flag",   0, 32'(flag), 32'd1);
        check("max_sum",    0, sum, 32'hFFFE_0001);
        check("max_result", 0, 32'(res), 32'd1);
        tick();
        check("max_flag_drop", 0, 32'(flag), 32'd0);
        check("max_sum_hold",  0, sum, 32'hFFFE_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
